// File: rtl/otter_branch_predictor.sv
// rtl/otter_branch_predictor.sv - BTB with saturating direction counters and invalidate sweep
module otter_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] LOOKUP_PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  input  logic            UPD_VALID,
  input  logic [XLEN-1:0] UPD_PC,
  input  logic            UPD_TAKEN,
  input  logic [XLEN-1:0] UPD_TARGET,
  input  logic            UPD_IS_JUMP,
  input  logic            INVALIDATE,
  output logic            BUSY
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = XLEN - 2 - IDX_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [IDX_BITS-1:0] LAST_PTR = IDX_BITS'(ENTRIES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state_q;
  logic [IDX_BITS-1:0]  ptr_q;

  logic                 valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]      target_q [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];

  // Lookup side: index/tag split of the fetch PC, word offset bits ignored
  logic [IDX_BITS-1:0]  lk_idx;
  logic [TAG_BITS-1:0]  lk_tag;
  logic                 lk_hit;

  assign lk_idx = LOOKUP_PC[IDX_BITS+1:2];
  assign lk_tag = LOOKUP_PC[XLEN-1:IDX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign BUSY        = (state_q == SWEEP);
  assign PRED_TAKEN  = lk_hit & ctr_q[lk_idx][CTR_BITS-1] & ~BUSY;
  assign PRED_TARGET = PRED_TAKEN ? target_q[lk_idx] : LOOKUP_PC + XLEN'(4);

  // Update side: same split applied to the resolved PC from execute
  logic [IDX_BITS-1:0]  up_idx;
  logic [TAG_BITS-1:0]  up_tag;
  logic                 up_hit;
  logic                 up_en;
  logic [CTR_BITS-1:0]  ctr_cur;
  logic [CTR_BITS-1:0]  ctr_next;
  logic [CTR_BITS-1:0]  ctr_alloc;
  logic                 unused_upd_lsb;

  assign up_idx         = UPD_PC[IDX_BITS+1:2];
  assign up_tag         = UPD_PC[XLEN-1:IDX_BITS+2];
  assign up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en          = UPD_VALID && (state_q == IDLE) && !RESET;
  assign ctr_cur        = ctr_q[up_idx];
  assign ctr_alloc      = UPD_IS_JUMP ? CTR_MAX : CTR_WEAK;
  assign unused_upd_lsb = &{1'b0, UPD_PC[1:0]};

  // Next counter value on a hit: jumps pin to strongly taken, branches saturate
  always_comb begin
    ctr_next = ctr_cur;
    if (UPD_IS_JUMP) begin
      ctr_next = CTR_MAX;
    end else if (UPD_TAKEN) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
    end
  end

  // Sweep FSM plus valid/counter writes; sweep owns the table while busy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        SWEEP: begin
          valid_q[ptr_q] <= 1'b0;
          ctr_q[ptr_q]   <= '0;
          ptr_q          <= ptr_q + 1'b1;
          if (ptr_q == LAST_PTR) state_q <= IDLE;
        end
        IDLE: begin
          if (UPD_VALID) begin
            if (up_hit) begin
              ctr_q[up_idx] <= ctr_next;
            end else if (UPD_TAKEN) begin
              valid_q[up_idx] <= 1'b1;
              ctr_q[up_idx]   <= ctr_alloc;
            end
          end
          if (INVALIDATE) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and target payload; never cleared, validity is tracked separately
  always_ff @(posedge CLK) begin
    if (up_en && UPD_TAKEN) begin
      target_q[up_idx] <= UPD_TARGET;
      if (!up_hit) tag_q[up_idx] <= up_tag;
    end
  end

endmodule

// File: tb/tb_otter_branch_predictor.sv
// tb/tb_otter_branch_predictor.sv - self-checking bench for otter_branch_predictor
module tb_otter_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int CTR_MAX  = 3;
  localparam int CTR_WEAK = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] LOOKUP_PC;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic        UPD_VALID;
  logic [31:0] UPD_PC;
  logic        UPD_TAKEN;
  logic [31:0] UPD_TARGET;
  logic        UPD_IS_JUMP;
  logic        INVALIDATE;
  logic        BUSY;

  always #5 CLK = ~CLK;

  otter_branch_predictor #(.XLEN(32), .ENTRIES(ENTRIES), .CTR_BITS(2)) dut (
    .CLK(CLK), .RESET(RESET), .LOOKUP_PC(LOOKUP_PC),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC), .UPD_TAKEN(UPD_TAKEN),
    .UPD_TARGET(UPD_TARGET), .UPD_IS_JUMP(UPD_IS_JUMP),
    .INVALIDATE(INVALIDATE), .BUSY(BUSY)
  );

  int checks = 0;
  int errors = 0;

  // Reference table keyed by word address; sweep modelled as a countdown
  bit          m_valid [ENTRIES];
  logic [29:0] m_word  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_sweep_left = 0;

  logic        obs_taken;
  logic [31:0] obs_target;
  logic        obs_busy;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[31:2]) % ENTRIES;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_word[idx_of(pc)] == pc[31:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int i;
    if (RESET) begin
      m_sweep_left = ENTRIES;
    end else if (m_sweep_left > 0) begin
      i = ENTRIES - m_sweep_left;
      m_valid[i] = 0;
      m_ctr[i] = 0;
      m_sweep_left--;
    end else begin
      if (UPD_VALID) begin
        i = idx_of(UPD_PC);
        if (m_hit(UPD_PC)) begin
          if (UPD_IS_JUMP) m_ctr[i] = CTR_MAX;
          else if (UPD_TAKEN) m_ctr[i] = (m_ctr[i] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[i] + 1;
          else m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          if (UPD_TAKEN) m_tgt[i] = UPD_TARGET;
        end else if (UPD_TAKEN) begin
          m_valid[i] = 1;
          m_word[i]  = UPD_PC[31:2];
          m_tgt[i]   = UPD_TARGET;
          m_ctr[i]   = UPD_IS_JUMP ? CTR_MAX : CTR_WEAK;
        end
      end
      if (INVALIDATE) m_sweep_left = ENTRIES;
    end
  endtask

  // One clock: drive, check combinational outputs mid-cycle, advance model at the edge
  task automatic cycle(input logic rst, input logic inv, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic uj, input logic [31:0] lpc);
    bit          e_busy, e_taken;
    logic [31:0] e_target;
    RESET = rst; INVALIDATE = inv; UPD_VALID = uv; UPD_PC = upc;
    UPD_TAKEN = ut; UPD_TARGET = utgt; UPD_IS_JUMP = uj; LOOKUP_PC = lpc;
    #3;
    e_busy   = (m_sweep_left > 0);
    e_taken  = !e_busy && m_hit(lpc) && (m_ctr[idx_of(lpc)] >= CTR_WEAK);
    e_target = e_taken ? m_tgt[idx_of(lpc)] : lpc + 32'd4;
    obs_taken = PRED_TAKEN; obs_target = PRED_TARGET; obs_busy = BUSY;
    check("busy", {31'd0, BUSY}, {31'd0, e_busy});
    check("pred_taken", {31'd0, PRED_TAKEN}, {31'd0, e_taken});
    check("pred_target", PRED_TARGET, e_target);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, lpc);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic j, input logic [31:0] lpc);
    cycle(1'b0, 1'b0, 1'b1, pc, t, tgt, j, lpc);
  endtask

  // Counts cycles with BUSY high; optionally fires a taken update on cycle drop_at
  task automatic count_busy(input int drop_at, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == drop_at) upd(32'h80, 1'b1, 32'h900, 1'b0, 32'h80);
      else idle(32'h100);
      if (!obs_busy) break;
      n++;
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'($urandom_range(0, 47)) << 2;
    if ($urandom_range(0, 3) == 0) pc = pc | 32'h8000_0000;
    return pc;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_word[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    RESET = 1; INVALIDATE = 0; UPD_VALID = 0; UPD_PC = 0; UPD_TAKEN = 0;
    UPD_TARGET = 0; UPD_IS_JUMP = 0; LOOKUP_PC = 32'h1234;
    @(posedge CLK); model_edge(); #1;

    // 1: reset state and sweep length
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h1234);
    check("reset_busy", {31'd0, obs_busy}, 32'd1);
    check("reset_target", obs_target, 32'h1238);
    count_busy(-1, n);
    check("reset_sweep_len", n, 32'd16);

    // 2: allocate weakly taken, then train down
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    idle(32'h100);
    check("t2_taken", {31'd0, obs_taken}, 32'd1);
    check("t2_target", obs_target, 32'h40);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    check("t2_nt_taken", {31'd0, obs_taken}, 32'd0);
    check("t2_nt_target", obs_target, 32'h104);

    // 3: aliasing and eviction
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    idle(32'h140);
    check("t3_alias_target", obs_target, 32'h144);
    upd(32'h140, 1'b1, 32'h80, 1'b0, 32'h0);
    idle(32'h100);
    check("t3_evicted", {31'd0, obs_taken}, 32'd0);
    idle(32'h140);
    check("t3_new_target", obs_target, 32'h80);

    // 4: saturation and jump allocation
    for (int k = 0; k < 5; k++) upd(32'h20, 1'b1, 32'h300, 1'b0, 32'h0);
    upd(32'h20, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h20);
    check("t4_sat_taken", {31'd0, obs_taken}, 32'd1);
    upd(32'h20, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h20);
    check("t4_sat_down", {31'd0, obs_taken}, 32'd0);
    upd(32'h3C, 1'b1, 32'h500, 1'b1, 32'h0);
    upd(32'h3C, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h3C);
    check("t4_jal_strong", {31'd0, obs_taken}, 32'd1);

    // 5: no bypass, and PC wrap
    upd(32'h200, 1'b1, 32'h600, 1'b0, 32'h200);
    check("t5_same_cycle", {31'd0, obs_taken}, 32'd0);
    idle(32'h200);
    check("t5_next_cycle", {31'd0, obs_taken}, 32'd1);
    idle(32'hFFFF_FFFC);
    check("t5_wrap", obs_target, 32'h0);

    // 6: invalidate with dropped update, then reset mid-sweep
    upd(32'h44, 1'b1, 32'h700, 1'b1, 32'h0);
    upd(32'h20, 1'b1, 32'h300, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0);
    count_busy(7, n);
    check("t6_sweep_len", n, 32'd16);
    idle(32'h200); check("t6_miss_200", {31'd0, obs_taken}, 32'd0);
    idle(32'h20);  check("t6_miss_20", {31'd0, obs_taken}, 32'd0);
    idle(32'h3C);  check("t6_miss_3c", {31'd0, obs_taken}, 32'd0);
    idle(32'h44);  check("t6_miss_44", {31'd0, obs_taken}, 32'd0);
    idle(32'h80);  check("t6_dropped", {31'd0, obs_taken}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0);
    for (int k = 0; k < 7; k++)
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0);
    count_busy(-1, n);
    check("t6_reset_restart", n, 32'd16);

    // Random traffic against the reference model
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 1) == 1), rand_pc() | 32'($urandom_range(0, 3)),
            ($urandom_range(0, 2) != 0), 32'($urandom) & 32'hFFFF_FFFC,
            ($urandom_range(0, 5) == 0), rand_pc() | 32'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
